fsc_seq: RTL and testbench

- Sequencer for the four-bank FFT scratch memory (4 banks × 64 words × 64 bits, shared write enable, 1-cycle registered read).
- Runs one in-place 256-point radix-4 FFT in three phases:
  - LOAD: streams samples into memory.
  - COMPUTE: issues 4 stages × 64 butterflies to an external butterfly unit and writes results back.
  - UNLOAD: streams memory contents out.
- Owns the conflict-free bank/address mapping and the lane rotation between memory ports and butterfly operands.

---
 rtl/fsc_pkg.sv | 42 ++++
 rtl/fsc_addr_gen.sv | 41 ++++
 rtl/fsc_seq.sv | 266 ++++++++++++++++++++++++++
 tb/tb_fsc_seq.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsc_pkg.sv
// rtl/fsc_pkg.sv - shared widths, state encoding and index mapping helpers for fsc_seq
//
// Purpose: constants for the 256-point radix-4 scratch memory, the sequencer
// state enum, and the bank/digit helpers used by the address generator and FSM.
// Ports: none (package).
package fsc_pkg;
  localparam int FSC_DATA_W = 64;
  localparam int FSC_STAGES = 4;
  localparam int FSC_N      = 4 ** FSC_STAGES;
  localparam int FSC_ADDR_W = 2 * FSC_STAGES - 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LD_WR,
    ST_RD,
    ST_CAP,
    ST_WT,
    ST_WR,
    ST_UR,
    ST_UC,
    ST_UO
  } state_t;

  // Sum of the four base-4 digits, wrapped to 2 bits.
  function automatic logic [1:0] bank_of(input logic [7:0] idx);
    return idx[7:6] + idx[5:4] + idx[3:2] + idx[1:0];
  endfunction

  // Insert base-4 digit k at digit position p of the 3-digit index j.
  function automatic logic [7:0] insert_digit(input logic [5:0] j, input logic [1:0] p,
                                              input logic [1:0] k);
    logic [7:0] n;
    case (p)
      2'd0:    n = {j, k};
      2'd1:    n = {j[5:2], k, j[1:0]};
      2'd2:    n = {j[5:4], k, j[3:0]};
      default: n = {k, j};
    endcase
    return n;
  endfunction
endpackage

// File: rtl/fsc_addr_gen.sv
// rtl/fsc_addr_gen.sv - per-bank addresses and lane rotation for one butterfly
//
// Purpose: for butterfly j of stage s, compute the memory address each bank
// must read/write and the rotation S (digit sum of j) relating banks to
// operand digits: operand k lives in bank (S+k) mod 4.
// Ports:
//   stage        in  2  stage s (operates on digit 3-s)
//   j            in  6  butterfly index within the stage
//   addr0..addr3 out 6  address for bank 0..3
//   rot          out 2  rotation S
module fsc_addr_gen
  import fsc_pkg::*;
(
  input  logic [1:0]            stage,
  input  logic [5:0]            j,
  output logic [FSC_ADDR_W-1:0] addr0,
  output logic [FSC_ADDR_W-1:0] addr1,
  output logic [FSC_ADDR_W-1:0] addr2,
  output logic [FSC_ADDR_W-1:0] addr3,
  output logic [1:0]            rot
);
  logic [1:0]            p;
  logic [7:0]            n;
  logic [FSC_ADDR_W-1:0] a [4];

  always_comb begin
    p   = 2'd3 - stage;
    rot = bank_of({j, 2'b00});
    n   = '0;
    for (int b = 0; b < 4; b++) begin
      // Bank b holds operand k = (b - S) mod 4.
      n    = insert_digit(j, p, 2'(b) - rot);
      a[b] = n[7:2];
    end
  end

  assign addr0 = a[0];
  assign addr1 = a[1];
  assign addr2 = a[2];
  assign addr3 = a[3];
endmodule

// File: rtl/fsc_seq.sv
// rtl/fsc_seq.sv - load / compute / unload sequencer for the four-bank FFT scratch memory
//
// Purpose: streams 256 samples into a 4-bank memory with conflict-free mapping,
// runs 4 radix-4 stages of 64 butterflies through an external unit, and
// streams the result back out in storage order.
// Ports:
//   CLK, RST                  clock, async active-high reset
//   START, BYPASS             run request (BYPASS skips compute)
//   BUSY, DONE                status, end-of-run pulse
//   IN_VALID/IN_READY/IN_DATA load stream
//   OUT_VALID/OUT_READY/OUT_DATA unload stream
//   MEM_WE, MEM_ADDR0..3, MEM_D0..3, MEM_Q0..3  bank memory interface
//   BF_VALID, BF_OP0..3, BF_STAGE, BF_IDX       butterfly operand issue
//   BF_RVALID, BF_RES0..3                        butterfly result return
module fsc_seq
  import fsc_pkg::*;
#(
  parameter int DATA_W = FSC_DATA_W,
  parameter int STAGES = FSC_STAGES
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic                     BYPASS,
  output logic                     BUSY,
  output logic                     DONE,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [DATA_W-1:0]        IN_DATA,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [DATA_W-1:0]        OUT_DATA,
  output logic                     MEM_WE,
  output logic [2*STAGES-3:0]      MEM_ADDR0,
  output logic [2*STAGES-3:0]      MEM_ADDR1,
  output logic [2*STAGES-3:0]      MEM_ADDR2,
  output logic [2*STAGES-3:0]      MEM_ADDR3,
  output logic [DATA_W-1:0]        MEM_D0,
  output logic [DATA_W-1:0]        MEM_D1,
  output logic [DATA_W-1:0]        MEM_D2,
  output logic [DATA_W-1:0]        MEM_D3,
  input  logic [DATA_W-1:0]        MEM_Q0,
  input  logic [DATA_W-1:0]        MEM_Q1,
  input  logic [DATA_W-1:0]        MEM_Q2,
  input  logic [DATA_W-1:0]        MEM_Q3,
  output logic                     BF_VALID,
  output logic [DATA_W-1:0]        BF_OP0,
  output logic [DATA_W-1:0]        BF_OP1,
  output logic [DATA_W-1:0]        BF_OP2,
  output logic [DATA_W-1:0]        BF_OP3,
  output logic [1:0]               BF_STAGE,
  output logic [5:0]               BF_IDX,
  input  logic                     BF_RVALID,
  input  logic [DATA_W-1:0]        BF_RES0,
  input  logic [DATA_W-1:0]        BF_RES1,
  input  logic [DATA_W-1:0]        BF_RES2,
  input  logic [DATA_W-1:0]        BF_RES3
);
  localparam int ADDR_W = 2 * STAGES - 2;
  localparam logic [ADDR_W-1:0] M_LAST = ADDR_W'(FSC_N / 4 - 1);

  state_t            state;
  logic              byp;
  logic [1:0]        lc;
  logic [1:0]        uc;
  logic [ADDR_W-1:0] mc;
  logic [7:0]        bc;    // {stage, j} of the next butterfly to issue
  logic [1:0]        rot;   // rotation S of the butterfly in flight

  logic [DATA_W-1:0] lbuf [3];
  logic [DATA_W-1:0] ubuf [4];
  logic [ADDR_W-1:0] mem_addr_r [4];
  logic [DATA_W-1:0] mem_d_r [4];

  logic [DATA_W-1:0] q_arr [4];
  logic [DATA_W-1:0] res_arr [4];
  logic [DATA_W-1:0] lane [4];
  logic [DATA_W-1:0] ld_d [4];
  logic [DATA_W-1:0] wr_d [4];
  logic [DATA_W-1:0] cap_op [4];
  logic [DATA_W-1:0] uc_q [4];
  logic [1:0]        sm;
  logic [ADDR_W-1:0] g_addr [4];
  logic [1:0]        g_rot;

  fsc_addr_gen u_addr_gen (
    .stage (bc[7:6]),
    .j     (bc[5:0]),
    .addr0 (g_addr[0]),
    .addr1 (g_addr[1]),
    .addr2 (g_addr[2]),
    .addr3 (g_addr[3]),
    .rot   (g_rot)
  );

  assign q_arr[0]   = MEM_Q0;
  assign q_arr[1]   = MEM_Q1;
  assign q_arr[2]   = MEM_Q2;
  assign q_arr[3]   = MEM_Q3;
  assign res_arr[0] = BF_RES0;
  assign res_arr[1] = BF_RES1;
  assign res_arr[2] = BF_RES2;
  assign res_arr[3] = BF_RES3;
  // The fourth load sample is routed straight from the input port so the
  // bank write can be launched on the same edge that accepts it.
  assign lane[0]    = lbuf[0];
  assign lane[1]    = lbuf[1];
  assign lane[2]    = lbuf[2];
  assign lane[3]    = IN_DATA;

  always_comb begin
    sm = bank_of({mc, 2'b00});
    for (int i = 0; i < 4; i++) begin
      ld_d[i]   = lane[2'(i) - sm];
      wr_d[i]   = res_arr[2'(i) - rot];
      cap_op[i] = q_arr[rot + 2'(i)];
      uc_q[i]   = q_arr[sm + 2'(i)];
    end
  end

  // Operands are the de-rotated read data, valid only during the CAP strobe.
  assign BF_OP0 = BF_VALID ? cap_op[0] : '0;
  assign BF_OP1 = BF_VALID ? cap_op[1] : '0;
  assign BF_OP2 = BF_VALID ? cap_op[2] : '0;
  assign BF_OP3 = BF_VALID ? cap_op[3] : '0;

  assign MEM_ADDR0 = mem_addr_r[0];
  assign MEM_ADDR1 = mem_addr_r[1];
  assign MEM_ADDR2 = mem_addr_r[2];
  assign MEM_ADDR3 = mem_addr_r[3];
  assign MEM_D0    = mem_d_r[0];
  assign MEM_D1    = mem_d_r[1];
  assign MEM_D2    = mem_d_r[2];
  assign MEM_D3    = mem_d_r[3];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      byp       <= 1'b0;
      lc        <= '0;
      uc        <= '0;
      mc        <= '0;
      bc        <= '0;
      rot       <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      IN_READY  <= 1'b0;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      MEM_WE    <= 1'b0;
      BF_VALID  <= 1'b0;
      BF_STAGE  <= '0;
      BF_IDX    <= '0;
      for (int i = 0; i < 3; i++) lbuf[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        ubuf[i]       <= '0;
        mem_addr_r[i] <= '0;
        mem_d_r[i]    <= '0;
      end
    end else begin
      DONE     <= 1'b0;
      BF_VALID <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            state    <= ST_LOAD;
            byp      <= BYPASS;
            BUSY     <= 1'b1;
            IN_READY <= 1'b1;
            lc       <= '0;
            mc       <= '0;
            bc       <= '0;
          end
        end
        ST_LOAD: begin
          if (IN_VALID && IN_READY) begin
            if (lc == 2'd3) begin
              IN_READY <= 1'b0;
              MEM_WE   <= 1'b1;
              for (int b = 0; b < 4; b++) begin
                mem_addr_r[b] <= mc;
                mem_d_r[b]    <= ld_d[b];
              end
              state <= ST_LD_WR;
            end else begin
              lbuf[lc] <= IN_DATA;
            end
            lc <= lc + 2'd1;
          end
        end
        ST_LD_WR: begin
          MEM_WE <= 1'b0;
          mc     <= mc + 1'b1;
          if (mc != M_LAST) begin
            state    <= ST_LOAD;
            IN_READY <= 1'b1;
          end else if (byp) begin
            state <= ST_UR;
            for (int b = 0; b < 4; b++) mem_addr_r[b] <= '0;
          end else begin
            state    <= ST_RD;
            rot      <= g_rot;
            BF_STAGE <= bc[7:6];
            BF_IDX   <= bc[5:0];
            bc       <= bc + 8'd1;
            for (int b = 0; b < 4; b++) mem_addr_r[b] <= g_addr[b];
          end
        end
        ST_RD: begin
          state    <= ST_CAP;
          BF_VALID <= 1'b1;
        end
        ST_CAP: state <= ST_WT;
        ST_WT: begin
          if (BF_RVALID) begin
            MEM_WE <= 1'b1;
            for (int b = 0; b < 4; b++) mem_d_r[b] <= wr_d[b];
            state <= ST_WR;
          end
        end
        ST_WR: begin
          MEM_WE <= 1'b0;
          if (BF_STAGE == 2'd3 && BF_IDX == 6'd63) begin
            state <= ST_UR;
            for (int b = 0; b < 4; b++) mem_addr_r[b] <= mc;
          end else begin
            state    <= ST_RD;
            rot      <= g_rot;
            BF_STAGE <= bc[7:6];
            BF_IDX   <= bc[5:0];
            bc       <= bc + 8'd1;
            for (int b = 0; b < 4; b++) mem_addr_r[b] <= g_addr[b];
          end
        end
        ST_UR: state <= ST_UC;
        ST_UC: begin
          for (int i = 0; i < 4; i++) ubuf[i] <= uc_q[i];
          OUT_DATA  <= uc_q[0];
          OUT_VALID <= 1'b1;
          uc        <= '0;
          state     <= ST_UO;
        end
        ST_UO: begin
          if (OUT_READY) begin
            if (uc == 2'd3) begin
              OUT_VALID <= 1'b0;
              if (mc == M_LAST) begin
                DONE  <= 1'b1;
                BUSY  <= 1'b0;
                state <= ST_IDLE;
              end else begin
                mc    <= mc + 1'b1;
                state <= ST_UR;
                for (int b = 0; b < 4; b++) mem_addr_r[b] <= mc + 1'b1;
              end
            end else begin
              OUT_DATA <= ubuf[uc + 2'd1];
            end
            uc <= uc + 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fsc_seq.sv
// tb/tb_fsc_seq.sv - directed self-checking bench for fsc_seq
module tb_fsc_seq;
  import fsc_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0, BYPASS = 1'b0;
  logic        BUSY, DONE;
  logic        IN_VALID = 1'b0, IN_READY;
  logic [63:0] IN_DATA = '0;
  logic        OUT_VALID, OUT_READY = 1'b0;
  logic [63:0] OUT_DATA;
  logic        MEM_WE;
  logic [5:0]  MEM_ADDR0, MEM_ADDR1, MEM_ADDR2, MEM_ADDR3;
  logic [63:0] MEM_D0, MEM_D1, MEM_D2, MEM_D3;
  logic [63:0] MEM_Q0, MEM_Q1, MEM_Q2, MEM_Q3;
  logic        BF_VALID;
  logic [63:0] BF_OP0, BF_OP1, BF_OP2, BF_OP3;
  logic [1:0]  BF_STAGE;
  logic [5:0]  BF_IDX;
  logic        BF_RVALID;
  logic [63:0] BF_RES0, BF_RES1, BF_RES2, BF_RES3;

  fsc_seq dut (
    .CLK(CLK), .RST(RST), .START(START), .BYPASS(BYPASS), .BUSY(BUSY), .DONE(DONE),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .MEM_WE(MEM_WE), .MEM_ADDR0(MEM_ADDR0), .MEM_ADDR1(MEM_ADDR1),
    .MEM_ADDR2(MEM_ADDR2), .MEM_ADDR3(MEM_ADDR3),
    .MEM_D0(MEM_D0), .MEM_D1(MEM_D1), .MEM_D2(MEM_D2), .MEM_D3(MEM_D3),
    .MEM_Q0(MEM_Q0), .MEM_Q1(MEM_Q1), .MEM_Q2(MEM_Q2), .MEM_Q3(MEM_Q3),
    .BF_VALID(BF_VALID), .BF_OP0(BF_OP0), .BF_OP1(BF_OP1), .BF_OP2(BF_OP2), .BF_OP3(BF_OP3),
    .BF_STAGE(BF_STAGE), .BF_IDX(BF_IDX), .BF_RVALID(BF_RVALID),
    .BF_RES0(BF_RES0), .BF_RES1(BF_RES1), .BF_RES2(BF_RES2), .BF_RES3(BF_RES3)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Four banks, registered read.
  logic [63:0] mem [4][64];
  always @(posedge CLK) begin
    if (MEM_WE) begin
      mem[0][MEM_ADDR0] <= MEM_D0;
      mem[1][MEM_ADDR1] <= MEM_D1;
      mem[2][MEM_ADDR2] <= MEM_D2;
      mem[3][MEM_ADDR3] <= MEM_D3;
    end
    MEM_Q0 <= mem[0][MEM_ADDR0];
    MEM_Q1 <= mem[1][MEM_ADDR1];
    MEM_Q2 <= mem[2][MEM_ADDR2];
    MEM_Q3 <= mem[3][MEM_ADDR3];
  end

  // Butterfly unit: echo or radix-4 (complex re[63:32], im[31:0]); twiddles are unity.
  int bf_lat = 1;
  int bf_mode = 0;
  logic [3:0]   pv = '0;
  logic [255:0] pr [4];

  function automatic logic [255:0] radix4(input logic [63:0] a, b, c, d);
    int ar, ai, br, bi, cr, ci, dr, di;
    int x0r, x0i, x1r, x1i, x2r, x2i, x3r, x3i;
    ar = $signed(a[63:32]); ai = $signed(a[31:0]);
    br = $signed(b[63:32]); bi = $signed(b[31:0]);
    cr = $signed(c[63:32]); ci = $signed(c[31:0]);
    dr = $signed(d[63:32]); di = $signed(d[31:0]);
    x0r = ar + br + cr + dr;  x0i = ai + bi + ci + di;
    x1r = ar + bi - cr - di;  x1i = ai - br - ci + dr;
    x2r = ar - br + cr - dr;  x2i = ai - bi + ci - di;
    x3r = ar - bi - cr + di;  x3i = ai + br - ci - dr;
    return {32'(x3r), 32'(x3i), 32'(x2r), 32'(x2i), 32'(x1r), 32'(x1i), 32'(x0r), 32'(x0i)};
  endfunction

  always @(posedge CLK) begin
    pv    <= {pv[2:0], BF_VALID};
    pr[0] <= (bf_mode == 1) ? radix4(BF_OP0, BF_OP1, BF_OP2, BF_OP3)
                            : {BF_OP3, BF_OP2, BF_OP1, BF_OP0};
    pr[1] <= pr[0];
    pr[2] <= pr[1];
    pr[3] <= pr[2];
  end
  wire [255:0] pr_sel = pr[bf_lat-1];
  assign BF_RVALID = pv[bf_lat-1];
  assign BF_RES0 = pr_sel[63:0];
  assign BF_RES1 = pr_sel[127:64];
  assign BF_RES2 = pr_sel[191:128];
  assign BF_RES3 = pr_sel[255:192];

  // Observation of outputs away from the active edge.
  logic [63:0] out_log [2048];
  int out_cnt = 0, last_acc = 0, done_cnt = 0, done_cyc = 0;
  int bf_cnt = 0, bf_last = 0, bf_period = 0, stall_err = 0, stall_seen = 0;
  logic busy_at_done = 1'b1;
  logic stall_p = 1'b0;
  logic [63:0] stall_d = '0;
  logic [23:0] prev_addr = '0, f_addr = '0;
  logic [63:0] f_op0 = '0, f_op1 = '0, f_op2 = '0, f_op3 = '0;
  logic [7:0]  bf_last_si = '0;

  always @(negedge CLK) begin
    if (OUT_VALID && OUT_READY) begin
      if (out_cnt < 2048) out_log[out_cnt] <= OUT_DATA;
      out_cnt  <= out_cnt + 1;
      last_acc <= cyc;
    end
    if (stall_p && (!OUT_VALID || OUT_DATA !== stall_d)) stall_err <= stall_err + 1;
    if (OUT_VALID && !OUT_READY) stall_seen <= stall_seen + 1;
    stall_p <= OUT_VALID && !OUT_READY;
    stall_d <= OUT_DATA;
    if (DONE) begin
      done_cnt     <= done_cnt + 1;
      done_cyc     <= cyc;
      busy_at_done <= BUSY;
    end
    if (BF_VALID) begin
      bf_cnt     <= bf_cnt + 1;
      bf_period  <= cyc - bf_last;
      bf_last    <= cyc;
      bf_last_si <= {BF_STAGE, BF_IDX};
      if (BF_STAGE == 2'd0 && BF_IDX == 6'd0) begin
        f_op0  <= BF_OP0; f_op1 <= BF_OP1; f_op2 <= BF_OP2; f_op3 <= BF_OP3;
        f_addr <= prev_addr;
      end
    end
    prev_addr <= {MEM_ADDR3, MEM_ADDR2, MEM_ADDR1, MEM_ADDR0};
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [63:0] sample(input int mode, input int n);
    case (mode)
      1:       return (n == 0) ? 64'h00000001_00000000 : 64'h0;
      2:       return {32'hA5A50000 | 32'(n), 32'(n * 3)};
      default: return 64'(n);
    endcase
  endfunction

  task automatic start_run(input logic byp);
    START  = 1'b1;
    BYPASS = byp;
    tick();
    START  = 1'b0;
    BYPASS = 1'b0;
  endtask

  task automatic load_sample(input logic [63:0] d);
    int w;
    IN_VALID = 1'b1;
    IN_DATA  = d;
    w = 0;
    while (1) begin
      @(negedge CLK);
      if (IN_READY) break;
      w++;
      if (w > 100) begin
        check("in_ready_timeout", 64'(w), 64'd0);
        break;
      end
    end
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic load_run(input int mode, input int cnt, input bit map_chk);
    for (int n = 0; n < cnt; n++) begin
      load_sample(sample(mode, n));
      if (map_chk && n == 23) begin
        check("map_we", 64'(MEM_WE), 64'd1);
        check("map_addr", 64'({MEM_ADDR3, MEM_ADDR2, MEM_ADDR1, MEM_ADDR0}), 64'({4{6'd5}}));
        check("map_bank2", MEM_D2, 64'd20);
        check("map_bank3", MEM_D3, 64'd21);
        check("map_bank0", MEM_D0, 64'd22);
        check("map_bank1", MEM_D1, 64'd23);
      end
    end
  endtask

  task automatic wait_done(input int rdy_mode, input int start_at);
    int d0;
    bit ok;
    d0 = done_cnt;
    ok = 0;
    for (int k = 0; k < 20000; k++) begin
      OUT_READY = (rdy_mode == 0) ? 1'b1 : ((k % 3) == 0);
      START     = (k == start_at);
      tick();
      if (done_cnt != d0) begin
        ok = 1;
        break;
      end
    end
    START     = 1'b0;
    OUT_READY = 1'b0;
    if (!ok) check("done_timeout", 64'd0, 64'd1);
    tick();
    tick();
  endtask

  task automatic check_out(input string tag, input int base, input int mode);
    int err;
    logic [63:0] exp;
    err = 0;
    for (int i = 0; i < FSC_N; i++) begin
      exp = (mode == 1) ? 64'h00000001_00000000 : sample(mode, i);
      if (base + i >= 2048 || out_log[base + i] !== exp) err++;
    end
    check(tag, 64'(err), 64'd0);
  endtask

  int o0, b0, d0;

  initial begin
    // Reset state
    #22;
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_in_ready", 64'(IN_READY), 64'd0);
    check("rst_outs", 64'(|{DONE, OUT_VALID, OUT_DATA, MEM_WE, BF_VALID, BF_STAGE, BF_IDX}), 64'd0);
    #11 RST = 1'b0;
    tick();

    // Asynchronous reset in the middle of a load
    d0 = done_cnt;
    start_run(1'b1);
    load_run(0, 37, 1'b0);
    #2 RST = 1'b1;
    #1;
    check("midrst_busy", 64'(BUSY), 64'd0);
    check("midrst_in_ready", 64'(IN_READY), 64'd0);
    check("midrst_outs", 64'(|{DONE, OUT_VALID, OUT_DATA, MEM_WE, MEM_ADDR0, MEM_ADDR1,
                               MEM_ADDR2, MEM_ADDR3, MEM_D0, MEM_D1, MEM_D2, MEM_D3, BF_VALID,
                               BF_OP0, BF_OP1, BF_OP2, BF_OP3, BF_STAGE, BF_IDX}), 64'd0);
    #3 RST = 1'b0;
    tick();
    tick();
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);

    // Bypass round trip with bank mapping check
    o0 = out_cnt; b0 = bf_cnt; d0 = done_cnt;
    start_run(1'b1);
    load_run(0, FSC_N, 1'b1);
    wait_done(0, -1);
    check("byp_count", 64'(out_cnt - o0), 64'd256);
    check_out("byp_data", o0, 0);
    check("byp_done_lat", 64'(done_cyc - last_acc), 64'd1);
    check("byp_busy_at_done", 64'(busy_at_done), 64'd0);
    check("byp_no_bf", 64'(bf_cnt - b0), 64'd0);
    check("byp_done_once", 64'(done_cnt - d0), 64'd1);

    // Compute with echo butterfly, RVALID 4 cycles after BF_VALID
    bf_mode = 0; bf_lat = 4;
    o0 = out_cnt; b0 = bf_cnt;
    start_run(1'b0);
    load_run(0, FSC_N, 1'b0);
    wait_done(0, -1);
    check("echo_addr", 64'(f_addr), 64'({6'd48, 6'd32, 6'd16, 6'd0}));
    check("echo_op0", f_op0, 64'd0);
    check("echo_op1", f_op1, 64'd64);
    check("echo_op2", f_op2, 64'd128);
    check("echo_op3", f_op3, 64'd192);
    check("echo_bf_count", 64'(bf_cnt - b0), 64'd256);
    check("echo_period", 64'(bf_period), 64'd7);
    check("echo_last_bf", 64'(bf_last_si), 64'hFF);
    check("echo_count", 64'(out_cnt - o0), 64'd256);
    check_out("echo_data", o0, 0);

    // Radix-4 arithmetic on an impulse, minimum butterfly latency
    bf_mode = 1; bf_lat = 1;
    o0 = out_cnt; b0 = bf_cnt;
    start_run(1'b0);
    load_run(1, FSC_N, 1'b0);
    wait_done(0, -1);
    check("fft_bf_count", 64'(bf_cnt - b0), 64'd256);
    check("fft_period", 64'(bf_period), 64'd4);
    check("fft_count", 64'(out_cnt - o0), 64'd256);
    check_out("fft_data", o0, 1);

    // Output backpressure, START while busy
    o0 = out_cnt; d0 = done_cnt; stall_seen = stall_seen;
    b0 = stall_seen;
    start_run(1'b1);
    load_run(2, FSC_N, 1'b0);
    wait_done(1, 50);
    check("bp_count", 64'(out_cnt - o0), 64'd256);
    check_out("bp_data", o0, 2);
    check("bp_stable", 64'(stall_err), 64'd0);
    check("bp_stalled", 64'(stall_seen - b0 > 0), 64'd1);
    for (int i = 0; i < 5; i++) tick();
    check("bp_idle_after", 64'(BUSY), 64'd0);
    check("bp_done_once", 64'(done_cnt - d0), 64'd1);
    check("bp_done_low", 64'(DONE), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
